// File: rtl/vect_mem_master.sv
// vect_mem_master: moves 1..16 beats of 256-bit data between simple
// request/stream interfaces and a vector memory port. Memory writes are
// synchronous and memory reads are combinational from mem_a.
// Optional feature: define VLSU_STRIDE_EN to add the req_stride input.
// When it is defined, the per-beat address increment comes from the
// request. When it is undefined, the increment is ADDR_STEP.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; req_ready high
// WR    | store burst; each wd_valid beat is written to mem_a
// RD    | load burst; beats captured from mem_rd into the rsp register
// DRAIN | last load beat held in the rsp register until accepted
module vect_mem_master #(
    parameter int ADDR_STEP = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [31:0]  req_addr,
    input  logic [3:0]   req_len,
`ifdef VLSU_STRIDE_EN
    input  logic [31:0]  req_stride,
`endif
    input  logic         wd_valid,
    input  logic [255:0] wd_data,
    output logic         wd_ready,
    output logic         rsp_valid,
    output logic         rsp_last,
    output logic [255:0] rsp_data,
    input  logic         rsp_ready,
    output logic         mem_we,
    output logic [31:0]  mem_a,
    output logic [255:0] mem_wd,
    input  logic [255:0] mem_rd,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] STEP_C = 32'(ADDR_STEP);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] cur_addr;
    logic [4:0]  remaining;
    logic [31:0] step;
    logic        accept;
    logic        wr_beat;
    logic        rd_cap;

`ifdef VLSU_STRIDE_EN
    logic [31:0] stride_q;

    // Capture the per-request stride; a zero stride re-reads one address
    always_ff @(posedge clk) begin
        if (rst)
            stride_q <= '0;
        else if (accept)
            stride_q <= req_stride;
    end

    assign step = stride_q;
`else
    assign step = STEP_C;
`endif

    // Next-state and handshake decode; reset masks anything that could write
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        wr_beat   = 1'b0;
        rd_cap    = 1'b0;
        req_ready = 1'b0;
        wd_ready  = 1'b0;
        mem_we    = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = req_we ? WR : RD;
                end
            end
            WR: begin
                wd_ready = !rst;
                if (wd_valid) begin
                    wr_beat = 1'b1;
                    mem_we  = !rst;
                    if (remaining == 5'd1)
                        state_nxt = IDLE;
                end
            end
            RD: begin
                // Capture whenever the output register is empty or being emptied
                if (!rsp_valid || rsp_ready) begin
                    rd_cap = 1'b1;
                    if (remaining == 5'd1)
                        state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Address and beat counter; address wraps modulo 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr  <= '0;
            remaining <= '0;
        end else if (accept) begin
            cur_addr  <= req_addr;
            remaining <= {1'b0, req_len} + 5'd1;
        end else if (wr_beat || rd_cap) begin
            cur_addr  <= cur_addr + step;
            remaining <= remaining - 5'd1;
        end
    end

    // Load response register; holds while rsp_valid and not rsp_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_data  <= '0;
        end else if (rd_cap) begin
            rsp_valid <= 1'b1;
            rsp_last  <= (remaining == 5'd1);
            rsp_data  <= mem_rd;
        end else if ((state == RD || state == DRAIN) && rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
        end
    end

    assign mem_a  = cur_addr;
    assign mem_wd = wd_data;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_vect_mem_master.sv
// Bench for vect_mem_master: directed corner cases plus randomized bursts,
// checked against expected addresses computed as addr + i*step and against
// the contents of a bench-side memory.
module tb_vect_mem_master;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [31:0]  req_addr;
    logic [3:0]   req_len;
    logic [31:0]  req_stride;
    logic         wd_valid;
    logic [255:0] wd_data;
    logic         wd_ready;
    logic         rsp_valid;
    logic         rsp_last;
    logic [255:0] rsp_data;
    logic         rsp_ready;
    logic         mem_we;
    logic [31:0]  mem_a;
    logic [255:0] mem_wd;
    logic [255:0] mem_rd;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [255:0] tb_mem [0:63];
    logic         mem_init;
    logic [255:0] wbuf [0:15];

    logic [31:0]  wr_a [$];
    logic [255:0] wr_d [$];
    logic [255:0] rs_d [$];
    logic         rs_l [$];
    logic [31:0]  aq [$];

    logic         prev_stall;
    logic [255:0] prev_data;
    logic [1:0]   prev_vl;

    vect_mem_master dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_len   (req_len),
`ifdef VLSU_STRIDE_EN
        .req_stride(req_stride),
`endif
        .wd_valid  (wd_valid),
        .wd_data   (wd_data),
        .wd_ready  (wd_ready),
        .rsp_valid (rsp_valid),
        .rsp_last  (rsp_last),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Vector memory model: 64 entries, indexed by address bits [9:4]
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++)
                tb_mem[i] <= {$urandom(), $urandom(), $urandom(), $urandom(),
                              $urandom(), $urandom(), $urandom(), $urandom()};
        end else if (mem_we) begin
            tb_mem[mem_a[9:4]] <= mem_wd;
        end
    end

    assign mem_rd = tb_mem[mem_a[9:4]];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Observe the DUT mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (mem_we) begin
            wr_a.push_back(mem_a);
            wr_d.push_back(mem_wd);
        end
        if (rsp_valid && rsp_ready) begin
            rs_d.push_back(rsp_data);
            rs_l.push_back(rsp_last);
        end
        if (busy && (aq.size() == 0 || aq[aq.size()-1] != mem_a))
            aq.push_back(mem_a);
        if (prev_stall && !rst) begin
            chk("rsp_hold_data", rsp_data, prev_data);
            chk("rsp_hold_vl", 256'({rsp_valid, rsp_last}), 256'(prev_vl));
        end
        prev_stall = rsp_valid && !rsp_ready && !rst;
        prev_data  = rsp_data;
        prev_vl    = {rsp_valid, rsp_last};
    end

    function automatic logic [31:0] eff_step(input logic [31:0] stride);
`ifdef VLSU_STRIDE_EN
        return stride;
`else
        return 32'd16 + (stride & 32'd0);
`endif
    endfunction

    task automatic clear_q();
        wr_a.delete();
        wr_d.delete();
        rs_d.delete();
        rs_l.delete();
        aq.delete();
    endtask

    task automatic junk_req();
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = $urandom();
        req_len   = 4'($urandom_range(0, 15));
        req_stride = $urandom();
    endtask

    task automatic send_req(input logic we, input logic [31:0] addr, input int len,
                            input logic [31:0] stride);
        clear_q();
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_len    = 4'(len);
        req_stride = stride;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] addr, input int len, input int lead,
                            input bit rnd, input logic [31:0] stride);
        int beat = 0;
        int cyc = 0;
        bit took;
        logic [31:0] st = eff_step(stride);
        send_req(1'b1, addr, len, stride);
        while (beat <= len && cyc < 200) begin
            wd_valid = (cyc >= lead) && (!rnd || $urandom_range(0, 3) != 0);
            wd_data  = wbuf[beat];
            if (rnd) junk_req();
            @(negedge clk);
            took = wd_valid && wd_ready;
            @(posedge clk);
            #1;
            if (took) beat++;
            cyc++;
        end
        wd_valid  = 1'b0;
        req_valid = 1'b0;
        chk("st_timeout", 256'(beat > len), 256'(1));
        chk("st_idle_after", 256'({busy, req_ready}), 256'(2'b01));
        chk("st_count", 256'(wr_a.size()), 256'(len + 1));
        for (int i = 0; i < wr_a.size() && i <= len; i++) begin
            chk("st_addr", 256'(wr_a[i]), 256'(addr + 32'(i) * st));
            chk("st_data", wr_d[i], wbuf[i]);
        end
    endtask

    task automatic do_load(input logic [31:0] addr, input int len, input int lead,
                           input bit rnd, input logic [31:0] stride);
        int cyc = 0;
        logic [31:0] st = eff_step(stride);
        logic [31:0] a;
        send_req(1'b0, addr, len, stride);
        while (busy && cyc < 200) begin
            rsp_ready = (cyc >= lead) && (!rnd || $urandom_range(0, 2) != 0);
            wd_valid  = 1'($urandom_range(0, 1));
            if (rnd) junk_req();
            @(posedge clk);
            #1;
            cyc++;
        end
        wd_valid  = 1'b0;
        req_valid = 1'b0;
        chk("ld_timeout", 256'(busy), 256'(0));
        chk("ld_no_write", 256'(wr_a.size()), 256'(0));
        chk("ld_count", 256'(rs_d.size()), 256'(len + 1));
        for (int i = 0; i < rs_d.size() && i <= len; i++) begin
            a = addr + 32'(i) * st;
            chk("ld_data", rs_d[i], tb_mem[a[9:4]]);
            chk("ld_last", 256'(rs_l[i]), 256'(i == len));
            if (st != 32'd0 && i < aq.size())
                chk("ld_addr", 256'(aq[i]), 256'(a));
        end
    endtask

    initial begin
        rst        = 1'b1;
        mem_init   = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_len    = '0;
        req_stride = '0;
        wd_valid   = 1'b0;
        wd_data    = '0;
        rsp_ready  = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_vl    = '0;
        repeat (3) @(posedge clk);
        #1;
        mem_init = 1'b0;
        @(negedge clk);
        chk("rst_mem_we", 256'(mem_we), 256'(0));
        chk("rst_wd_ready", 256'(wd_ready), 256'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_req_ready", 256'(req_ready), 256'(1));
        chk("rst_rsp_valid", 256'({rsp_valid, rsp_last}), 256'(0));
        chk("rst_rsp_data", rsp_data, 256'(0));
        chk("rst_mem_a", 256'(mem_a), 256'(0));
        @(posedge clk);
        #1;

        // single-beat store with a fixed pattern
        wbuf[0] = {4{64'hF55F_6F6B_4AA8_6F6B}};
        do_store(32'd32, 0, 0, 1'b0, 32'd16);

        // two-beat store with a two-cycle leading stall
        wbuf[0] = {8{32'h1111_2222}};
        wbuf[1] = {8{32'h3333_4444}};
        do_store(32'd32, 1, 2, 1'b0, 32'd16);

        // two-beat load with rsp_ready low for three cycles
        do_load(32'd32, 1, 3, 1'b0, 32'd16);

        // address wrap across 2^32
        do_load(32'hFFFF_FFF0, 1, 0, 1'b0, 32'd16);

`ifdef VLSU_STRIDE_EN
        do_load(32'd64, 2, 0, 1'b0, 32'd32);
`endif

        // reset in the middle of a 16-beat store
        for (int i = 0; i < 16; i++) wbuf[i] = {8{$urandom()}};
        send_req(1'b1, 32'd0, 15, 32'd16);
        wd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wd_data = wbuf[i];
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_mem_we", 256'({mem_we, wd_ready}), 256'(0));
        @(posedge clk);
        #1;
        rst      = 1'b0;
        wd_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_idle", 256'({busy, req_ready}), 256'(2'b01));
        chk("mid_rst_writes", 256'(wr_a.size()), 256'(5));
        @(posedge clk);
        #1;

        // reset in the middle of a load
        send_req(1'b0, 32'h100, 7, 32'd16);
        rsp_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready = 1'b0;
        chk("ld_rst_rsp", 256'({rsp_valid, rsp_last, busy}), 256'(0));
        @(posedge clk);
        #1;

        // randomized bursts with stalls and ignored side inputs
        for (int k = 0; k < 24; k++) begin
            logic [31:0] ra = $urandom();
            int rl = $urandom_range(0, 15);
            logic [31:0] rs = 32'($urandom_range(0, 4)) * 32'd16;
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++)
                    wbuf[i] = {$urandom(), $urandom(), $urandom(), $urandom(),
                               $urandom(), $urandom(), $urandom(), $urandom()};
                do_store(ra, rl, 0, 1'b1, rs);
            end else begin
                do_load(ra, rl, 0, 1'b1, rs);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
